// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler slice.
package alu_sched_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    int   idx;
    logic found;

    // Walk the requesters starting at ptr and pick the first one that is valid
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = IW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among N_REQ requesters: grant, issue, capture, respond.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [ALU_OP_W*N_REQ-1:0] req_op,
    input  logic [WIDTH*N_REQ-1:0]    req_a,
    input  logic [WIDTH*N_REQ-1:0]    req_b,
    output logic [ALU_OP_W-1:0]       alu_op,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    input  logic [WIDTH-1:0]          alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   winner;
    logic [N_REQ-1:0]  grant;
    logic              grant_en;
    logic              granted;

    // A new op may issue from IDLE, or from RESP in the cycle the response retires;
    // gating with rst_n keeps every grant low while the block is held in reset
    assign grant_en  = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign req_ready = grant;
    assign granted   = |grant;
    assign busy      = (state != IDLE);

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (grant_en),
        .grant  (grant),
        .winner (winner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a grant always leads to EXEC, EXEC always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (granted) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = granted ? EXEC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch the winner's op onto the ALU, then capture and hold its result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            id_q      <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (granted) begin
                alu_op <= req_op[ALU_OP_W*winner +: ALU_OP_W];
                alu_a  <= req_a[WIDTH*winner +: WIDTH];
                alu_b  <= req_b[WIDTH*winner +: WIDTH];
                id_q   <= winner;
                ptr    <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_result;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
